// File: rtl/vlt_pkg.sv
// Shared VLT definitions: default field widths and the lifetime record layout
// used by the tracker and the downstream weighting blocks.
package vlt_pkg;

  localparam int TS_W  = 10;
  localparam int OPC_W = 9;

  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic             important;
    logic [TS_W-1:0]  start_ts;
    logic [TS_W-1:0]  end_ts;
  } vlt_rec_t;

endpackage

// File: rtl/vlt_rec_fifo.sv
// Synchronous show-ahead FIFO of lifetime records; a push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module vlt_rec_fifo
  import vlt_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     push_i,
  input  vlt_rec_t data_i,
  input  logic     pop_i,
  output vlt_rec_t data_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int AW = $clog2(DEPTH);

  vlt_rec_t      mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic          do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/vlt_sq_tracker.sv
// Store-queue lifetime tracker: timestamps entries on allocate and emits one
// {opcode, important, start_ts, end_ts} record per deallocation of a live entry.
module vlt_sq_tracker
  import vlt_pkg::*;
#(
  parameter int ENTRIES    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        alloc_v_i,
  input  logic [$clog2(ENTRIES)-1:0]  alloc_idx_i,
  input  logic [OPC_W-1:0]            alloc_opcode_i,
  input  logic                        alloc_important_i,
  input  logic                        dealloc_v_i,
  input  logic [$clog2(ENTRIES)-1:0]  dealloc_idx_i,
  input  logic                        flush_i,
  output logic                        rec_v_o,
  input  logic                        rec_ready_i,
  output logic [OPC_W-1:0]            rec_opcode_o,
  output logic                        rec_important_o,
  output logic [TS_W-1:0]             rec_start_ts_o,
  output logic [TS_W-1:0]             rec_end_ts_o,
  output logic [$clog2(ENTRIES):0]    live_cnt_o,
  output logic                        alloc_err_o,
  output logic [7:0]                  drop_cnt_o
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [TS_W-1:0]    ts_q;
  logic [ENTRIES-1:0] valid_q;
  logic [ENTRIES-1:0] important_q;
  logic [TS_W-1:0]    start_ts_q [ENTRIES];
  logic [OPC_W-1:0]   opcode_q   [ENTRIES];
  logic               alloc_err_q;
  logic [7:0]         drop_cnt_q;

  logic     dealloc_hit, alloc_err_d, fifo_pop, fifo_full, fifo_empty, drop_d;
  vlt_rec_t push_rec, head_rec;

  assign dealloc_hit = dealloc_v_i && valid_q[dealloc_idx_i];
  assign alloc_err_d = alloc_v_i && valid_q[alloc_idx_i] && !flush_i &&
                       !(dealloc_v_i && (dealloc_idx_i == alloc_idx_i));

  always_comb begin
    push_rec           = '0;
    push_rec.opcode    = opcode_q[dealloc_idx_i];
    push_rec.important = important_q[dealloc_idx_i];
    push_rec.start_ts  = start_ts_q[dealloc_idx_i];
    push_rec.end_ts    = ts_q;
  end

  assign fifo_pop = rec_ready_i && !fifo_empty;
  assign drop_d   = dealloc_hit && fifo_full && !fifo_pop && (drop_cnt_q != 8'hFF);

  vlt_rec_fifo #(.DEPTH(FIFO_DEPTH)) u_rec_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (dealloc_hit),
    .data_i  (push_rec),
    .pop_i   (fifo_pop),
    .data_o  (head_rec),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Clears are scheduled before the alloc set so a same-cycle alloc always wins.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ts_q        <= '0;
      valid_q     <= '0;
      important_q <= '0;
      alloc_err_q <= 1'b0;
      drop_cnt_q  <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        start_ts_q[i] <= '0;
        opcode_q[i]   <= '0;
      end
    end else begin
      ts_q        <= ts_q + 1'b1;
      alloc_err_q <= alloc_err_d;
      if (drop_d) drop_cnt_q <= drop_cnt_q + 8'd1;
      for (int i = 0; i < ENTRIES; i++) begin
        if (flush_i || (dealloc_hit && (dealloc_idx_i == IDX_W'(i))))
          valid_q[i] <= 1'b0;
        if (alloc_v_i && (alloc_idx_i == IDX_W'(i))) begin
          valid_q[i]     <= 1'b1;
          start_ts_q[i]  <= ts_q;
          opcode_q[i]    <= alloc_opcode_i;
          important_q[i] <= alloc_important_i;
        end
      end
    end
  end

  always_comb begin
    live_cnt_o = '0;
    for (int i = 0; i < ENTRIES; i++)
      live_cnt_o = live_cnt_o + {{IDX_W{1'b0}}, valid_q[i]};
  end

  assign rec_v_o         = !fifo_empty;
  assign rec_opcode_o    = fifo_empty ? '0   : head_rec.opcode;
  assign rec_important_o = fifo_empty ? 1'b0 : head_rec.important;
  assign rec_start_ts_o  = fifo_empty ? '0   : head_rec.start_ts;
  assign rec_end_ts_o    = fifo_empty ? '0   : head_rec.end_ts;
  assign alloc_err_o     = alloc_err_q;
  assign drop_cnt_o      = drop_cnt_q;

endmodule

// File: tb/tb_vlt_sq_tracker.sv
// Directed bench for vlt_sq_tracker: a vector table for the single-cycle cases
// plus hand sequences for wrap-around, back-pressure, flush and async reset.
module tb_vlt_sq_tracker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       alloc_v = 1'b0, alloc_imp = 1'b0, dealloc_v = 1'b0, flush = 1'b0, ready = 1'b1;
  logic [3:0] alloc_idx = '0, dealloc_idx = '0;
  logic [8:0] alloc_opc = '0;
  logic       rec_v, rec_imp, alloc_err;
  logic [8:0] rec_opc;
  logic [9:0] rec_start, rec_end;
  logic [4:0] live_cnt;
  logic [7:0] drop_cnt;

  int checks = 0;
  int errors = 0;
  logic [9:0] tb_ts;

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) tb_ts <= '0;
    else        tb_ts <= tb_ts + 10'd1;

  vlt_sq_tracker dut (
    .clk_i(clk), .rst_ni(rst_n),
    .alloc_v_i(alloc_v), .alloc_idx_i(alloc_idx), .alloc_opcode_i(alloc_opc),
    .alloc_important_i(alloc_imp),
    .dealloc_v_i(dealloc_v), .dealloc_idx_i(dealloc_idx), .flush_i(flush),
    .rec_v_o(rec_v), .rec_ready_i(ready), .rec_opcode_o(rec_opc),
    .rec_important_o(rec_imp), .rec_start_ts_o(rec_start), .rec_end_ts_o(rec_end),
    .live_cnt_o(live_cnt), .alloc_err_o(alloc_err), .drop_cnt_o(drop_cnt)
  );

  typedef struct {
    logic av; logic [3:0] ai; logic [8:0] ao; logic aim;
    logic dv; logic [3:0] di; logic fl; logic rdy;
    logic ev; logic [8:0] eo; logic eim; logic [9:0] es; logic [9:0] ee;
    logic [4:0] el; logic eerr; logic [7:0] ed;
  } vec_t;

  vec_t tbl [21];

  function automatic vec_t mk(logic av, logic [3:0] ai, logic [8:0] ao, logic aim,
                              logic dv, logic [3:0] di, logic ev, logic [8:0] eo,
                              logic eim, logic [9:0] es, logic [9:0] ee,
                              logic [4:0] el, logic eerr);
    vec_t v;
    v.av = av; v.ai = ai; v.ao = ao; v.aim = aim; v.dv = dv; v.di = di;
    v.fl = 1'b0; v.rdy = 1'b1; v.ev = ev; v.eo = eo; v.eim = eim;
    v.es = es; v.ee = ee; v.el = el; v.eerr = eerr; v.ed = 8'd0;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_rec(input string nm, input logic [8:0] o, input logic im,
                         input logic [9:0] s, input logic [9:0] e);
    chk({nm, "_v"}, 32'(rec_v), 32'd1);
    chk({nm, "_opc"}, 32'(rec_opc), 32'(o));
    chk({nm, "_imp"}, 32'(rec_imp), 32'(im));
    chk({nm, "_start"}, 32'(rec_start), 32'(s));
    chk({nm, "_end"}, 32'(rec_end), 32'(e));
  endtask

  task automatic idle();
    alloc_v = 1'b0; dealloc_v = 1'b0; flush = 1'b0;
  endtask

  task automatic do_alloc(input logic [3:0] i, input logic [8:0] o, input logic im);
    alloc_v = 1'b1; alloc_idx = i; alloc_opc = o; alloc_imp = im;
  endtask

  task automatic do_dealloc(input logic [3:0] i);
    dealloc_v = 1'b1; dealloc_idx = i;
  endtask

  task automatic wait_ts(input logic [9:0] t);
    int n = 0;
    while (tb_ts != t && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      errors++;
      $display("FAIL wait_ts: timestamp %0d never reached %0d", tb_ts, t);
    end
  endtask

  logic [9:0] a_ts [5];
  logic [9:0] d_ts [5];
  logic [9:0] t_a1, t_fl, t_d;

  initial begin
    for (int i = 0; i < 4; i++) tbl[i] = mk(0,0,0,0, 0,0, 0,0,0,0,0, 0,0);
    tbl[4]  = mk(1,2,9'h021,0, 0,0, 0,0,0,0,0, 1,0);
    tbl[5]  = mk(1,3,9'h008,1, 0,0, 0,0,0,0,0, 2,0);
    for (int i = 6; i < 9; i++) tbl[i] = mk(0,0,0,0, 0,0, 0,0,0,0,0, 2,0);
    tbl[9]  = mk(1,2,9'h00F,1, 1,2, 1,9'h021,0,4,9, 2,0);
    tbl[10] = mk(0,0,0,0, 0,0, 0,0,0,0,0, 2,0);
    tbl[11] = mk(0,0,0,0, 0,0, 0,0,0,0,0, 2,0);
    tbl[12] = mk(0,0,0,0, 1,3, 1,9'h008,1,5,12, 1,0);
    tbl[13] = mk(0,0,0,0, 0,0, 0,0,0,0,0, 1,0);
    tbl[14] = mk(0,0,0,0, 1,2, 1,9'h00F,1,9,14, 0,0);
    tbl[15] = mk(0,0,0,0, 1,2, 0,0,0,0,0, 0,0);
    tbl[16] = mk(1,5,9'h1AB,0, 0,0, 0,0,0,0,0, 1,0);
    tbl[17] = mk(1,5,9'h055,1, 0,0, 0,0,0,0,0, 1,1);
    tbl[18] = mk(0,0,0,0, 0,0, 0,0,0,0,0, 1,0);
    tbl[19] = mk(0,0,0,0, 1,5, 1,9'h055,1,17,19, 0,0);
    tbl[20] = mk(0,0,0,0, 0,0, 0,0,0,0,0, 0,0);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_rec_v", 32'(rec_v), 0);
    chk("rst_fields", {rec_opc, rec_imp, rec_start, rec_end}, 0);
    chk("rst_live", 32'(live_cnt), 0);
    chk("rst_err", 32'(alloc_err), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      alloc_v = tbl[i].av; alloc_idx = tbl[i].ai; alloc_opc = tbl[i].ao;
      alloc_imp = tbl[i].aim; dealloc_v = tbl[i].dv; dealloc_idx = tbl[i].di;
      flush = tbl[i].fl; ready = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("vec%0d_rec_v", i), 32'(rec_v), 32'(tbl[i].ev));
      chk($sformatf("vec%0d_rec", i), {rec_opc, rec_imp, rec_start, rec_end},
          {tbl[i].eo, tbl[i].eim, tbl[i].es, tbl[i].ee});
      chk($sformatf("vec%0d_live", i), 32'(live_cnt), 32'(tbl[i].el));
      chk($sformatf("vec%0d_err", i), 32'(alloc_err), 32'(tbl[i].eerr));
      chk($sformatf("vec%0d_drop", i), 32'(drop_cnt), 32'(tbl[i].ed));
    end
    idle();

    // Timestamp wrap-around
    ready = 1'b0;
    wait_ts(10'd1020);
    do_alloc(4'd0, 9'h100, 1'b0);
    @(negedge clk); idle();
    wait_ts(10'd6);
    do_dealloc(4'd0);
    @(negedge clk); idle();
    chk_rec("wrap", 9'h100, 1'b0, 10'd1020, 10'd6);
    chk("wrap_len", 32'((rec_end - rec_start) & 10'h3FF), 32'd10);
    ready = 1'b1;
    @(negedge clk);
    chk("wrap_drained", 32'(rec_v), 0);

    // Back-pressure: five records into a four-deep buffer
    ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      do_alloc(4'(8 + k), 9'(9'h040 + k), 1'(k));
      a_ts[k] = tb_ts;
      @(negedge clk);
    end
    idle();
    chk("bp_live5", 32'(live_cnt), 32'd5);
    for (int k = 0; k < 5; k++) begin
      do_dealloc(4'(8 + k));
      d_ts[k] = tb_ts;
      @(negedge clk);
    end
    idle();
    chk("bp_drop", 32'(drop_cnt), 32'd1);
    chk_rec("bp_head", 9'h040, 1'b0, a_ts[0], d_ts[0]);
    @(negedge clk);
    chk_rec("bp_head_stable", 9'h040, 1'b0, a_ts[0], d_ts[0]);
    ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk_rec($sformatf("bp_drain%0d", k), 9'(9'h040 + k), 1'(k), a_ts[k], d_ts[k]);
      @(negedge clk);
    end
    chk("bp_empty", 32'(rec_v), 0);
    chk("bp_live0", 32'(live_cnt), 0);
    chk("bp_drop_hold", 32'(drop_cnt), 32'd1);

    // Flush with same-cycle alloc and dealloc
    do_alloc(4'd1, 9'h011, 1'b0); t_a1 = tb_ts;
    @(negedge clk);
    do_alloc(4'd4, 9'h044, 1'b1);
    @(negedge clk);
    do_alloc(4'd6, 9'h066, 1'b0);
    @(negedge clk); idle();
    chk("fl_live3", 32'(live_cnt), 32'd3);
    flush = 1'b1; do_alloc(4'd7, 9'h077, 1'b1); do_dealloc(4'd1); t_fl = tb_ts;
    @(negedge clk); idle();
    chk_rec("fl_rec", 9'h011, 1'b0, t_a1, t_fl);
    chk("fl_live1", 32'(live_cnt), 32'd1);
    do_dealloc(4'd4);
    @(negedge clk); idle();
    chk("fl_dead_no_rec", 32'(rec_v), 0);
    chk("fl_dead_live", 32'(live_cnt), 32'd1);
    do_dealloc(4'd7); t_d = tb_ts;
    @(negedge clk); idle();
    chk_rec("fl_alloc_won", 9'h077, 1'b1, t_fl, t_d);
    chk("fl_live0", 32'(live_cnt), 0);
    @(negedge clk);

    // Asynchronous reset with a buffered record and a live entry
    ready = 1'b0;
    do_alloc(4'd9, 9'h099, 1'b0);
    @(negedge clk);
    do_alloc(4'd10, 9'h0AA, 1'b1); do_dealloc(4'd9);
    @(negedge clk); idle();
    chk("ar_pre_v", 32'(rec_v), 1);
    chk("ar_pre_live", 32'(live_cnt), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_rec_v", 32'(rec_v), 0);
    chk("ar_fields", {rec_opc, rec_imp, rec_start, rec_end}, 0);
    chk("ar_live", 32'(live_cnt), 0);
    chk("ar_drop", 32'(drop_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;
    do_dealloc(4'd10);
    @(negedge clk); idle();
    chk("ar_entry_gone", 32'(rec_v), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
